// File: rtl/adder_pkg.sv
// Shared types and defaults for the sequential chunked adder.
// The state encoding lives here so every file agrees on it.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // A one-chunk adder still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle for seq_chunk_adder.
// The op pin exists only when ADDER_SUB_EN is defined.
interface seq_chunk_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef ADDER_SUB_EN
    logic             op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef ADDER_SUB_EN
    modport master (output start, a, b, carry_in, op,
                    input  busy, done, sum, carry_out);
    modport slave  (input  start, a, b, carry_in, op,
                    output busy, done, sum, carry_out);
`else
    modport master (output start, a, b, carry_in,
                    input  busy, done, sum, carry_out);
    modport slave  (input  start, a, b, carry_in,
                    output busy, done, sum, carry_out);
`endif

endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder, shared by every chunk
// of the sequential adder.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out
);

    logic ripple;

    always_comb begin
        ripple = carry_in;
        sum    = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ ripple;
            ripple = (a[i] & b[i]) | (ripple & (a[i] ^ b[i]));
        end
        carry_out = ripple;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per RUN cycle through a single
// chunk_adder. Defining ADDER_SUB_EN adds the op pin (1 = a - b).
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic               clk,
    input logic               rst_n,
    seq_chunk_adder_if.slave  bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = idx_width(N);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             carry_out_reg;
    logic [IDX_W-1:0] idx;
    logic             last;

    logic [WIDTH-1:0] b_capture;
    logic             carry_capture;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co;

    // Subtraction is folded in at capture time as a + ~b + 1.
`ifdef ADDER_SUB_EN
    assign b_capture     = bus.op ? ~bus.b : bus.b;
    assign carry_capture = bus.op ? 1'b1   : bus.carry_in;
`else
    assign b_capture     = bus.b;
    assign carry_capture = bus.carry_in;
`endif

    assign chunk_a = a_reg[idx*CHUNK +: CHUNK];
    assign chunk_b = b_reg[idx*CHUNK +: CHUNK];
    assign last    = (idx == IDX_W'(N - 1));

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a        (chunk_a),
        .b        (chunk_b),
        .carry_in (carry),
        .sum      (chunk_sum),
        .carry_out(chunk_co)
    );

    always_comb begin
        acc_next = acc;
        acc_next[idx*CHUNK +: CHUNK] = chunk_sum;
    end

    // sum is written only from the completed accumulator, so partial
    // results never reach the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            sum_reg       <= '0;
            carry         <= 1'b0;
            carry_out_reg <= 1'b0;
            idx           <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg <= bus.a;
                        b_reg <= b_capture;
                        carry <= carry_capture;
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= chunk_co;
                    if (last) begin
                        sum_reg       <= acc_next;
                        carry_out_reg <= chunk_co;
                        state         <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_reg;
    assign bus.carry_out = carry_out_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed scoreboard bench for seq_chunk_adder (16/4 and 8/8 instances).
// Subtraction steps run only when ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic [15:0] sum;
        logic        co;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [15:0] last_sum = '0;
    logic        last_co  = 1'b0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) bus ();
    seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; the start is accepted on the next rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic op);
        logic [16:0] full;
        if (op)
            full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else
            full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
`ifdef ADDER_SUB_EN
        bus.op       = op;
`endif
        sb.push_back({full[15:0], full[16]});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Sample k=1 is the first falling edge after the accepting rising edge.
    task automatic checkOutput(input string tag, input int inject_at);
        int   k;
        int   busy_cycles;
        exp_t exp;
        k           = 1;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && k <= 20) begin
            if (bus.busy === 1'b1) busy_cycles++;
            check_value({tag, "_sum_hold"}, 32'(bus.sum), 32'(last_sum));
            if (k == inject_at) begin
                bus.start    = 1'b1;
                bus.a        = 16'h1111;
                bus.b        = 16'h2222;
                bus.carry_in = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check_value({tag, "_done"}, 32'(bus.done), 32'd1);
        check_value({tag, "_latency"}, 32'(k), 32'd5);
        check_value({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd4);
        check_value({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check_value({tag, "_sum"}, 32'(bus.sum), 32'(exp.sum));
        check_value({tag, "_carry_out"}, 32'(bus.carry_out), 32'(exp.co));
        last_sum = exp.sum;
        last_co  = exp.co;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_count;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus8.start    = 1'b0;
        bus8.a        = '0;
        bus8.b        = '0;
        bus8.carry_in = 1'b0;
`ifdef ADDER_SUB_EN
        bus.op        = 1'b0;
        bus8.op       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_value("reset_busy", 32'(bus.busy), 32'd0);
        check_value("reset_done", 32'(bus.done), 32'd0);
        check_value("reset_sum", 32'(bus.sum), 32'd0);
        check_value("reset_carry_out", 32'(bus.carry_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic add 0x0001 + 0x0002");
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
        checkOutput("s1", 0);
        @(negedge clk);
        check_value("s1_done_single", 32'(bus.done), 32'd0);
        check_value("s1_idle_busy", 32'(bus.busy), 32'd0);
        check_value("s1_sum_hold", 32'(bus.sum), 32'h0003);
        check_value("s1_co_hold", 32'(bus.carry_out), 32'(last_co));

        $display("[TB] full ripple 0xFFFF + 0x0001");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("s2", 0);
        @(negedge clk);

        $display("[TB] start ignored in RUN, back-to-back start in DONE");
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        checkOutput("s3", 2);
        applyStimulus(16'h0006, 16'h0009, 1'b0, 1'b0);
        check_value("s3_done_pulse", 32'(bus.done), 32'd0);
        check_value("s3_back_to_back_busy", 32'(bus.busy), 32'd1);
        checkOutput("s3b", 0);
        @(negedge clk);

        $display("[TB] reset during RUN");
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("abort_busy", 32'(bus.busy), 32'd0);
        check_value("abort_done", 32'(bus.done), 32'd0);
        check_value("abort_sum", 32'(bus.sum), 32'd0);
        check_value("abort_carry_out", 32'(bus.carry_out), 32'd0);
        sb.delete();
        last_sum = '0;
        last_co  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_count++;
        end
        check_value("abort_no_done", 32'(done_count), 32'd0);
        applyStimulus(16'h0007, 16'h0003, 1'b1, 1'b0);
        checkOutput("s4", 0);
        @(negedge clk);

`ifdef ADDER_SUB_EN
        $display("[TB] subtraction");
        applyStimulus(16'h0007, 16'h0003, 1'b0, 1'b1);
        checkOutput("sub_pos", 0);
        @(negedge clk);
        applyStimulus(16'h0003, 16'h0007, 1'b1, 1'b1);
        checkOutput("sub_neg", 0);
        @(negedge clk);
`endif

        $display("[TB] single-chunk instance 0xFF + 0x01");
        bus8.start    = 1'b1;
        bus8.a        = 8'hFF;
        bus8.b        = 8'h01;
        bus8.carry_in = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        check_value("w8_busy", 32'(bus8.busy), 32'd1);
        check_value("w8_not_done_yet", 32'(bus8.done), 32'd0);
        @(negedge clk);
        check_value("w8_done", 32'(bus8.done), 32'd1);
        check_value("w8_busy_at_done", 32'(bus8.busy), 32'd0);
        check_value("w8_sum", 32'(bus8.sum), 32'h00);
        check_value("w8_carry_out", 32'(bus8.carry_out), 32'd1);
        @(negedge clk);
        check_value("w8_done_single", 32'(bus8.done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle. WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset. Both are named as everywhere in the codebase: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin an addition; sampled on the clk rising edge.
REQ-007 a  input  WIDTH  operand A; captured when start is accepted.
REQ-008 b  input  WIDTH  operand B; captured when start is accepted.
REQ-009 carry_in  input  1  carry into bit 0; captured when start is accepted.
REQ-010 op  input  1  0 = add, 1 = subtract; present only when ADDER_SUB_EN is defined.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 sum  output  WIDTH  registered result.
REQ-014 carry_out  output  1  registered carry out of bit WIDTH-1.

Function
REQ-015 SHALL be an FSM with the states IDLE, RUN and DONE. N = WIDTH/CHUNK.
REQ-016 IDLE: start=1 captures a, b, carry_in (and op), clears the chunk index, then goes to RUN. start=0 stays in IDLE.
REQ-017 RUN: each cycle, chunk i computes a[i] + b[i] + c. It writes the CHUNK-bit result into internal accumulator slice i, and the chunk's carry becomes c for chunk i+1.
REQ-018 RUN: after chunk N-1, the FSM goes to DONE. It copies the accumulator into sum and the final carry into carry_out on that same edge.
REQ-019 DONE: done=1 for exactly one cycle.
REQ-020 DONE: start=1 is accepted exactly as in IDLE and the FSM goes directly to RUN (back-to-back operation). Otherwise it returns to IDLE.
REQ-021 Latency: with start accepted at edge t, busy is high for cycles t+1..t+N. done, sum and carry_out are valid in the cycle after edge t+N.
REQ-022 start during RUN SHALL be ignored. Captured operands SHALL NOT change mid-operation, even if the input pins change.
REQ-023 sum and carry_out SHALL hold their values until the next completion. Partial results SHALL never be visible on sum.
REQ-024 Arithmetic is modulo 2^WIDTH. carry_out is bit WIDTH of a + b + carry_in.
REQ-025 N = 1 (CHUNK = WIDTH) SHALL be legal: one RUN cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, sum=0, carry_out=0, accumulator=0, carry=0, index=0.
REQ-027 Reset during RUN SHALL abort the operation. No done pulse is produced for it. The first start after rst_n rises is processed normally.

Configuration
REQ-028 Macro ADDER_SUB_EN defined: the op port exists. With op=1 captured, the block computes a + ~b + 1, ignoring carry_in. carry_out=1 means no borrow.
REQ-029 ADDER_SUB_EN undefined: no op port and addition only. Timing and all other behaviour are identical.

Structure
REQ-030 Shared package adder_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the default WIDTH and CHUNK constants.
REQ-031 One sub-module, chunk_adder: a combinational CHUNK-bit ripple-carry adder with carry in and carry out. It SHALL be instantiated once and time-multiplexed across the chunks.

Verification
REQ-032 All scenarios use WIDTH=16, CHUNK=4. The bench SHALL cover:
- a=0x0001, b=0x0002, cin=0 -> sum=0x0003, co=0; done exactly 5 cycles after the start edge; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, co=1 (carry ripples through all 4 chunks).
- a=0xA5A5, b=0x5A5A, cin=1 -> sum=0x0000, co=1. A second start issued during RUN with different operands is ignored. A start in the DONE cycle with a=0x0006, b=0x0009 yields sum=0x000F, co=0 four cycles later.
- Reset asserted in the 2nd RUN cycle -> all outputs 0 immediately and no done. A next start with 0x0007+0x0003, cin=1 -> 0x000B, co=0.
- With ADDER_SUB_EN: 0x0007-0x0003 -> 0x0004, co=1; 0x0003-0x0007 -> 0xFFFC, co=0.
- WIDTH=CHUNK=8: 0xFF+0x01 -> 0x00, co=1, with done 2 cycles after start.
